// File: rtl/lc3b_mem_unit_pkg.sv
// Shared LC-3b types for the memory stage: word/byte types, the opcode
// encoding, the slice of the decode control word this stage consumes and
// the memory-sequencer state enum.
package lc3b_mem_unit_pkg;

  typedef logic [15:0] lc3b_word;
  typedef logic [7:0]  lc3b_byte;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef struct packed {
    lc3b_opcode opcode;
    logic       mem_read;
    logic       mem_write;
  } lc3b_control_word;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACC1 = 2'b01,
    ACC2 = 2'b10,
    DONE = 2'b11
  } lc3b_mem_state;

  function automatic logic is_byte_op(input lc3b_opcode op);
    return (op == op_ldb) || (op == op_stb);
  endfunction

  function automatic logic is_indirect_op(input lc3b_opcode op);
    return (op == op_ldi) || (op == op_sti);
  endfunction

endpackage

// File: rtl/lc3b_byte_lane.sv
// Byte-lane steering for the data-memory port: byte enables and replicated
// write data for STB, and zero-extended byte extraction for LDB. Word
// accesses pass through with both lanes enabled.
module lc3b_byte_lane
  import lc3b_mem_unit_pkg::*;
(
  input  logic       byte_op,
  input  logic       store_op,
  input  logic       addr0,
  input  lc3b_word   store_data,
  input  lc3b_word   rdata,
  output logic [1:0] byte_enable,
  output lc3b_word   wdata,
  output lc3b_word   load_data
);

  lc3b_byte sel_byte;

  // Select lanes from address bit 0; the odd byte lives in the high half.
  always_comb begin
    sel_byte    = addr0 ? rdata[15:8] : rdata[7:0];
    byte_enable = 2'b11;
    wdata       = store_data;
    load_data   = rdata;
    if (byte_op) begin
      wdata     = {store_data[7:0], store_data[7:0]};
      load_data = {8'h00, sel_byte};
      if (store_op) begin
        byte_enable = addr0 ? 2'b10 : 2'b01;
      end
    end
  end

endmodule

// File: rtl/lc3b_mem_unit.sv
// LC-3b memory-stage sequencer: runs the data-memory handshake for
// LDR/STR/LDB/STB/LDI/STI/TRAP (including the two-access indirect forms),
// stalls upstream until the access retires and holds the load result.
// Optional feature macro: LC3B_MEM_ALIGN_CHECK_EN (odd word accesses are
// flagged as misaligned instead of silently rounded down).
module lc3b_mem_unit
  import lc3b_mem_unit_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid_in,
  input  lc3b_control_word ctrl,
  input  lc3b_word         address,
  input  lc3b_word         store_data,
  output lc3b_word         dmem_address,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic [1:0]       dmem_byte_enable,
  output lc3b_word         dmem_wdata,
  input  lc3b_word         dmem_rdata,
  input  logic             dmem_resp,
  output lc3b_word         mem_data_out,
  output logic             stall,
  output logic             done,
  output logic             misaligned
);

  lc3b_mem_state state_reg, state_next;
  lc3b_opcode    opcode_reg;
  lc3b_word      addr_reg, sdata_reg, mem_data_reg;
  logic [15:1]   ptr_reg;

  logic       mem_op, is_byte, is_ind, acc1_write, acc2_write;
  logic       misalign_start, misalign_ptr;
  logic [1:0] lane_be;
  lc3b_word   lane_wdata, lane_load;

  assign mem_op     = valid_in & (ctrl.mem_read | ctrl.mem_write);
  assign is_byte    = is_byte_op(opcode_reg);
  assign is_ind     = is_indirect_op(opcode_reg);
  assign acc1_write = (opcode_reg == op_str) || (opcode_reg == op_stb);
  assign acc2_write = (opcode_reg == op_sti);

  lc3b_byte_lane u_lane (
    .byte_op     (is_byte),
    .store_op    (acc1_write),
    .addr0       (addr_reg[0]),
    .store_data  (sdata_reg),
    .rdata       (dmem_rdata),
    .byte_enable (lane_be),
    .wdata       (lane_wdata),
    .load_data   (lane_load)
  );

`ifdef LC3B_MEM_ALIGN_CHECK_EN
  logic misalign_reg;
  assign misalign_start = ~is_byte_op(ctrl.opcode) & address[0];
  assign misalign_ptr   = is_ind & dmem_rdata[0];
  assign misaligned     = (state_reg == DONE) & misalign_reg;

  // Remember whether the current op was aborted for alignment.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      misalign_reg <= 1'b0;
    end else if (state_reg == IDLE && mem_op) begin
      misalign_reg <= misalign_start;
    end else if (state_reg == ACC1 && dmem_resp && misalign_ptr) begin
      misalign_reg <= 1'b1;
    end
  end
`else
  assign misalign_start = 1'b0;
  assign misalign_ptr   = 1'b0;
  assign misaligned     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next-state: each access state waits for its response; DONE lasts one cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (mem_op) state_next = misalign_start ? DONE : ACC1;
      ACC1: if (dmem_resp) state_next = (is_ind && !misalign_ptr) ? ACC2 : DONE;
      ACC2: if (dmem_resp) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Latch the instruction on entry, the pointer after ACC1 and load results on retire.
  // Stores leave mem_data_out untouched; only reads produce a result.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      opcode_reg   <= op_br;
      addr_reg     <= '0;
      sdata_reg    <= '0;
      ptr_reg      <= '0;
      mem_data_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: if (mem_op) begin
          opcode_reg <= ctrl.opcode;
          addr_reg   <= address;
          sdata_reg  <= store_data;
          if (misalign_start) mem_data_reg <= '0;
        end
        ACC1: if (dmem_resp) begin
          if (is_ind) begin
            ptr_reg <= dmem_rdata[15:1];
            if (misalign_ptr) mem_data_reg <= '0;
          end else if (!acc1_write) begin
            mem_data_reg <= lane_load;
          end
        end
        ACC2: if (dmem_resp && !acc2_write) mem_data_reg <= dmem_rdata;
        default: ;
      endcase
    end
  end

  // Drive the memory port only while an access state is active.
  always_comb begin
    dmem_address     = '0;
    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
    dmem_byte_enable = 2'b00;
    dmem_wdata       = '0;
    case (state_reg)
      ACC1: begin
        dmem_address     = is_byte ? addr_reg : {addr_reg[15:1], 1'b0};
        dmem_write       = acc1_write;
        dmem_read        = ~acc1_write;
        dmem_byte_enable = lane_be;
        dmem_wdata       = lane_wdata;
      end
      ACC2: begin
        dmem_address     = {ptr_reg, 1'b0};
        dmem_write       = acc2_write;
        dmem_read        = ~acc2_write;
        dmem_byte_enable = 2'b11;
        dmem_wdata       = sdata_reg;
      end
      default: ;
    endcase
  end

  assign stall        = ((state_reg == IDLE) & mem_op) | (state_reg == ACC1) | (state_reg == ACC2);
  assign done         = (state_reg == DONE);
  assign mem_data_out = mem_data_reg;

endmodule

// File: tb/tb_lc3b_mem_unit.sv
// Self-checking bench for lc3b_mem_unit. Each memory op is expanded into a
// cycle-by-cycle timeline of expected port values derived from the access
// rules (which accesses occur, at which address, with which lanes/data and
// how many wait cycles), against a sparse word-addressed memory model.
// Follows LC3B_MEM_ALIGN_CHECK_EN the same way as the design.
module tb_lc3b_mem_unit;
  import lc3b_mem_unit_pkg::*;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             valid_in;
  lc3b_control_word ctrl;
  logic [15:0]      address, store_data;
  logic [15:0]      dmem_address, dmem_wdata, dmem_rdata, mem_data_out;
  logic             dmem_read, dmem_write, dmem_resp, stall, done, misaligned;
  logic [1:0]       dmem_byte_enable;

  lc3b_mem_unit dut (
    .clk (clk), .reset_n (reset_n), .valid_in (valid_in), .ctrl (ctrl),
    .address (address), .store_data (store_data),
    .dmem_address (dmem_address), .dmem_read (dmem_read), .dmem_write (dmem_write),
    .dmem_byte_enable (dmem_byte_enable), .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata), .dmem_resp (dmem_resp),
    .mem_data_out (mem_data_out), .stall (stall), .done (done), .misaligned (misaligned)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        req;
    logic        wr;
    logic [15:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
    logic        stall;
    logic        done;
    logic        mis;
  } exp_t;

  exp_t        exp_cur;
  logic [15:0] exp_mdo;
  logic [15:0] mem [logic [15:0]];
  int          n_vec = 0, n_err = 0;
  bit          chk_en = 1'b0;
  int          stall_cnt = 0, done_cnt = 0, wr_cnt = 0, mis_cnt = 0;
  logic [15:0] last_wr_addr = '0, last_wr_data = '0, last_rd_addr = '0;
  logic [1:0]  last_wr_be = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // Per-cycle comparison of every output against the current expectation.
  always @(negedge clk) begin
    if (chk_en) begin
      check("dmem_read",  dmem_read,  exp_cur.req & ~exp_cur.wr);
      check("dmem_write", dmem_write, exp_cur.req & exp_cur.wr);
      check("dmem_address", dmem_address, exp_cur.req ? exp_cur.addr : 16'h0);
      check("dmem_byte_enable", dmem_byte_enable, exp_cur.req ? exp_cur.be : 2'b00);
      check("dmem_wdata", dmem_wdata, exp_cur.req ? exp_cur.wdata : 16'h0);
      check("stall", stall, exp_cur.stall);
      check("done", done, exp_cur.done);
      check("misaligned", misaligned, exp_cur.mis);
      check("mem_data_out", mem_data_out, exp_mdo);
      if (stall) stall_cnt++;
      if (done) done_cnt++;
      if (misaligned) mis_cnt++;
      if (dmem_write) begin
        wr_cnt++; last_wr_addr = dmem_address; last_wr_be = dmem_byte_enable; last_wr_data = dmem_wdata;
      end
      if (dmem_read) last_rd_addr = dmem_address;
    end
  end

  task automatic mem_rd(input logic [15:0] a, output logic [15:0] d);
    logic [15:0] k;
    k = {a[15:1], 1'b0};
    if (!mem.exists(k)) mem[k] = 16'($urandom);
    d = mem[k];
  endtask

  task automatic mem_wr(input logic [15:0] a, input logic [1:0] be, input logic [15:0] d);
    logic [15:0] k, w;
    k = {a[15:1], 1'b0};
    mem_rd(k, w);
    if (be[1]) w[15:8] = d[15:8];
    if (be[0]) w[7:0]  = d[7:0];
    mem[k] = w;
  endtask

  task automatic drive(input exp_t e, input logic v, input lc3b_control_word c,
                       input logic [15:0] a, input logic [15:0] sd,
                       input logic r, input logic [15:0] rd);
    valid_in = v; ctrl = c; address = a; store_data = sd;
    dmem_resp = r; dmem_rdata = rd; exp_cur = e;
    @(posedge clk); #1;
  endtask

  // One access: w wait cycles with the request held, then the response cycle.
  task automatic access(input exp_t e, input lc3b_control_word c, input logic [15:0] a,
                        input logic [15:0] sd, input int w, input logic [15:0] rd);
    for (int i = 0; i < w; i++) drive(e, 1'b1, c, a, sd, 1'b0, 16'($urandom));
    drive(e, 1'b1, c, a, sd, 1'b1, rd);
  endtask

  task automatic run_op(input lc3b_opcode op, input logic [15:0] a, input logic [15:0] sd,
                        input int w1, input int w2, input bit spurious);
    lc3b_control_word c;
    exp_t e;
    logic [15:0] rd, p, res;
    bit byte_op, ind, mis;
    c.opcode    = op;
    c.mem_read  = !(op == op_str || op == op_stb);
    c.mem_write = (op == op_str || op == op_stb || op == op_sti);
    byte_op = (op == op_ldb || op == op_stb);
    ind     = (op == op_ldi || op == op_sti);
    mis     = 1'b0;
    res     = exp_mdo;
`ifdef LC3B_MEM_ALIGN_CHECK_EN
    if (!byte_op && a[0]) mis = 1'b1;
`endif
    e = '0; e.stall = 1'b1;
    drive(e, 1'b1, c, a, sd, 1'b0, 16'($urandom));
    if (!mis) begin
      e.req   = 1'b1;
      e.addr  = byte_op ? a : {a[15:1], 1'b0};
      e.wr    = (op == op_str || op == op_stb);
      e.be    = (op == op_stb) ? (a[0] ? 2'b10 : 2'b01) : 2'b11;
      e.wdata = byte_op ? {sd[7:0], sd[7:0]} : sd;
      if (e.wr) rd = 16'($urandom); else mem_rd(e.addr, rd);
      access(e, c, a, sd, w1, rd);
      if (e.wr) mem_wr(e.addr, e.be, e.wdata);
      if (op == op_ldr || op == op_trap) res = rd;
      if (op == op_ldb) res = {8'h00, a[0] ? rd[15:8] : rd[7:0]};
      if (ind) begin
        p = rd;
`ifdef LC3B_MEM_ALIGN_CHECK_EN
        if (p[0]) mis = 1'b1;
`endif
        if (!mis) begin
          e.addr = {p[15:1], 1'b0}; e.wr = (op == op_sti); e.be = 2'b11; e.wdata = sd;
          if (e.wr) rd = 16'($urandom); else mem_rd(e.addr, rd);
          access(e, c, a, sd, w2, rd);
          if (e.wr) mem_wr(e.addr, e.be, e.wdata); else res = rd;
        end
      end
    end
    if (mis) res = 16'h0;
    exp_mdo = res;
    e = '0; e.done = 1'b1; e.mis = mis;
    drive(e, 1'b1, c, a, sd, spurious, 16'($urandom));
  endtask

  // Idle cycle: no op, a non-valid memory op, or a non-memory op with a stray response.
  task automatic gap_cycle();
    lc3b_control_word c;
    int k;
    k = $urandom_range(0, 2);
    c.opcode = (k == 1) ? op_ldr : op_add;
    c.mem_read = (k == 1); c.mem_write = 1'b0;
    drive('0, (k == 2), c, 16'($urandom), 16'($urandom), (k == 2), 16'($urandom));
  endtask

  initial begin
    lc3b_opcode ops [7];
    lc3b_control_word c;
    exp_t e;
    int s0, d0;
    ops = '{op_ldr, op_str, op_ldb, op_stb, op_ldi, op_sti, op_trap};
    c = '0;
    reset_n = 1'b0; exp_mdo = 16'h0;
    drive('0, 1'b0, c, 16'h0, 16'h0, 1'b0, 16'h0);
    chk_en = 1'b1;
    drive('0, 1'b0, c, 16'h0, 16'h0, 1'b1, 16'hFFFF);
    reset_n = 1'b1;
    gap_cycle();

    // LDR, odd address rounded down, zero-wait.
    mem[16'h1000] = 16'hBEEF;
    s0 = stall_cnt;
    run_op(op_ldr, 16'h1001, 16'h0, 0, 0, 1'b0);
    check("ldr_data", mem_data_out, 16'hBEEF);
    check("ldr_addr", last_rd_addr, 16'h1000);
    check("ldr_stall_cycles", stall_cnt - s0, 2);

    // LDB both lanes.
    mem[16'h2002] = 16'hA55A;
    run_op(op_ldb, 16'h2003, 16'h0, 1, 0, 1'b1);
    check("ldb_hi", mem_data_out, 16'h00A5);
    run_op(op_ldb, 16'h2002, 16'h0, 0, 0, 1'b0);
    check("ldb_lo", mem_data_out, 16'h005A);

    // STB high lane, single write cycle.
    s0 = wr_cnt;
    run_op(op_stb, 16'h3001, 16'h1234, 0, 0, 1'b0);
    check("stb_be", last_wr_be, 2'b10);
    check("stb_wdata", last_wr_data, 16'h3434);
    check("stb_write_cycles", wr_cnt - s0, 1);

    // LDI with two wait cycles on each access; back-to-back after STB.
    mem[16'h4000] = 16'h5000; mem[16'h5000] = 16'h0042;
    d0 = done_cnt; s0 = stall_cnt;
    run_op(op_ldi, 16'h4000, 16'h0, 2, 2, 1'b0);
    check("ldi_data", mem_data_out, 16'h0042);
    check("ldi_ptr_addr", last_rd_addr, 16'h5000);
    check("ldi_done_count", done_cnt - d0, 1);
    check("ldi_stall_cycles", stall_cnt - s0, 7);

    // STI interrupted by reset during ACC2, then a late response.
    mem[16'h6000] = 16'h7000;
    c.opcode = op_sti; c.mem_read = 1'b1; c.mem_write = 1'b1;
    s0 = wr_cnt;
    e = '0; e.stall = 1'b1;
    drive(e, 1'b1, c, 16'h6000, 16'h9999, 1'b0, 16'h0);
    e.req = 1'b1; e.addr = 16'h6000; e.be = 2'b11; e.wdata = 16'h9999;
    drive(e, 1'b1, c, 16'h6000, 16'h9999, 1'b1, 16'h7000);
    e.wr = 1'b1; e.addr = 16'h7000;
    reset_n = 1'b0;
    drive(e, 1'b1, c, 16'h6000, 16'h9999, 1'b0, 16'h0);
    reset_n = 1'b1; exp_mdo = 16'h0;
    drive('0, 1'b0, c, 16'h6000, 16'h9999, 1'b1, 16'h1111);
    drive('0, 1'b0, c, 16'h6000, 16'h9999, 1'b0, 16'h0);
    check("sti_reset_writes", wr_cnt - s0 - 1, 0);
    check("sti_reset_mdo", mem_data_out, 16'h0);

    // Word store to an odd address.
    s0 = wr_cnt; d0 = mis_cnt;
    run_op(op_str, 16'h0007, 16'hCAFE, 0, 0, 1'b0);
`ifdef LC3B_MEM_ALIGN_CHECK_EN
    check("str_odd_no_write", wr_cnt - s0, 0);
    check("str_odd_misaligned", mis_cnt - d0, 1);
`else
    check("str_odd_addr", last_wr_addr, 16'h0006);
    check("str_odd_no_flag", mis_cnt - d0, 0);
`endif

    // Randomized mix with random waits, gaps and stray responses.
    for (int i = 0; i < 150; i++) begin
      run_op(ops[$urandom_range(0, 6)], 16'h0100 + 16'($urandom_range(0, 63)), 16'($urandom),
             $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) gap_cycle();
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
